// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequenced command/response wrapper around a single 8-bit ALU
// Runs one-cycle logic/arith ops or an 8-step shift-add multiply through the same ALU.

module ALU_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic [1:0] op,
    output logic [7:0] result,
    output logic       overflow
);
    logic [7:0] aa;
    logic [7:0] bb;
    logic [7:0] sum;

    always_comb begin
        aa       = ainvert ? ~a : a;
        bb       = binvert ? ~b : b;
        // binvert doubles as carry-in so SUB/SLT form a + ~b + 1
        sum      = aa + bb + {7'd0, binvert};
        overflow = (aa[7] == bb[7]) && (sum[7] != aa[7]);
        case (op)
            2'b00:   result = aa & bb;
            2'b01:   result = aa | bb;
            2'b10:   result = sum;
            default: result = {7'd0, sum[7] ^ overflow};
        endcase
    end
endmodule

module alu_seq_ctrl #(
    parameter int unsigned MUL_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_zero,
    output logic       rsp_overflow,
    output logic       rsp_err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    logic [1:0] state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] mcand_q, mcand_d;
    logic [7:0] mplier_q, mplier_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] res_q, res_d;
    logic       zero_q, zero_d;
    logic       ovf_q, ovf_d;
    logic       err_q, err_d;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_ainv;
    logic       alu_binv;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_ovf;
    logic [7:0] acc_next;
    logic       mul_illegal;

    ALU_8bit u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .ainvert  (alu_ainv),
        .binvert  (alu_binv),
        .op       (alu_op),
        .result   (alu_result),
        .overflow (alu_ovf)
    );

    assign mul_illegal = (MUL_EN == 0);

    // Operand/control mux: multiply steps reuse the adder path, otherwise decode op_q
    always_comb begin
        alu_a    = a_q;
        alu_b    = b_q;
        alu_ainv = 1'b0;
        alu_binv = 1'b0;
        alu_op   = 2'b10;
        if (state_q == ST_MUL) begin
            alu_a = acc_q;
            alu_b = mcand_q;
        end else begin
            case (op_q)
                OP_AND:  begin alu_ainv = 1'b0; alu_binv = 1'b0; alu_op = 2'b00; end
                OP_OR:   begin alu_ainv = 1'b0; alu_binv = 1'b0; alu_op = 2'b01; end
                OP_SUB:  begin alu_ainv = 1'b0; alu_binv = 1'b1; alu_op = 2'b10; end
                OP_SLT:  begin alu_ainv = 1'b0; alu_binv = 1'b1; alu_op = 2'b11; end
                OP_NOR:  begin alu_ainv = 1'b1; alu_binv = 1'b1; alu_op = 2'b00; end
                default: begin alu_ainv = 1'b0; alu_binv = 1'b0; alu_op = 2'b10; end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        acc_next = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    a_d  = cmd_a;
                    b_d  = cmd_b;
                    if (cmd_op == OP_ILL || (cmd_op == OP_MUL && mul_illegal)) begin
                        state_d = ST_DONE;
                        res_d   = 8'h00;
                        zero_d  = 1'b1;
                        ovf_d   = 1'b0;
                        err_d   = 1'b1;
                    end else if (cmd_op == OP_MUL) begin
                        state_d  = ST_MUL;
                        acc_d    = 8'h00;
                        mcand_d  = cmd_a;
                        mplier_d = cmd_b;
                        cnt_d    = 3'd0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                res_d   = alu_result;
                zero_d  = (alu_result == 8'h00);
                ovf_d   = (op_q == OP_ADD || op_q == OP_SUB) ? alu_ovf : 1'b0;
                err_d   = 1'b0;
            end
            ST_MUL: begin
                if (mplier_q[0]) begin
                    acc_next = alu_result;
                end
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                // Eighth step: the counter wraps to zero on its own
                if (cnt_q == 3'd7) begin
                    state_d = ST_DONE;
                    res_d   = acc_next;
                    zero_d  = (acc_next == 8'h00);
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            acc_q    <= 8'h00;
            mcand_q  <= 8'h00;
            mplier_q <= 8'h00;
            cnt_q    <= 3'd0;
            res_q    <= 8'h00;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_DONE);
    assign rsp_result   = res_q;
    assign rsp_zero     = zero_q;
    assign rsp_overflow = ovf_q;
    assign rsp_err      = err_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed and random checks of alu_seq_ctrl against a behavioural model

module tb_alu_seq_ctrl;
    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_overflow;
    logic       rsp_err;

    logic       cmd_valid0;
    logic       cmd_ready0;
    logic       rsp_valid0;
    logic       rsp_ready0;
    logic [7:0] rsp_result0;
    logic       rsp_zero0;
    logic       rsp_overflow0;
    logic       rsp_err0;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       ovf;
        logic       err;
        int         lat;
    } exp_t;

    alu_seq_ctrl #(.MUL_EN(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err)
    );

    alu_seq_ctrl #(.MUL_EN(0)) dut_nomul (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid0),
        .cmd_ready    (cmd_ready0),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .rsp_valid    (rsp_valid0),
        .rsp_ready    (rsp_ready0),
        .rsp_result   (rsp_result0),
        .rsp_zero     (rsp_zero0),
        .rsp_overflow (rsp_overflow0),
        .rsp_err      (rsp_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Latency counts cycles after the accept edge: cycle 1 is the one right after it
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input bit mul_en);
        exp_t e;
        int sa;
        int sb;
        int s;
        logic [15:0] prod;
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.res = 8'h00;
        e.ovf = 1'b0;
        e.err = 1'b0;
        e.lat = 2;
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: begin
                s = sa + sb;
                e.res = 8'(a + b);
                e.ovf = (s > 127) || (s < -128);
            end
            3'd3: begin
                s = sa - sb;
                e.res = 8'(a - b);
                e.ovf = (s > 127) || (s < -128);
            end
            3'd4: e.res = (sa < sb) ? 8'h01 : 8'h00;
            3'd5: e.res = ~(a | b);
            3'd6: begin
                if (mul_en) begin
                    prod  = 16'(a) * 16'(b);
                    e.res = prod[7:0];
                    e.lat = 9;
                end else begin
                    e.err = 1'b1;
                    e.lat = 1;
                end
            end
            default: begin
                e.err = 1'b1;
                e.lat = 1;
            end
        endcase
        e.zero = (e.res == 8'h00);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int hold);
        exp_t e;
        int   lat;
        e = model(op, a, b, 1'b1);
        @(negedge clk);
        check("cmd_ready_before", 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(e.lat));
        check("result", 32'(rsp_result), 32'(e.res));
        check("zero", 32'(rsp_zero), 32'(e.zero));
        check("overflow", 32'(rsp_overflow), 32'(e.ovf));
        check("err", 32'(rsp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'($urandom);
            cmd_op    = 3'($urandom);
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_result", 32'(rsp_result), 32'(e.res));
            check("hold_flags", {29'd0, rsp_zero, rsp_overflow, rsp_err}, {29'd0, e.zero, e.ovf, e.err});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int quiet;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_valid0 = 1'b0;
        cmd_op     = 3'd0;
        cmd_a      = 8'h00;
        cmd_b      = 8'h00;
        rsp_ready  = 1'b0;
        rsp_ready0 = 1'b0;
        #12;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_fields", {20'd0, rsp_result, 1'b0, rsp_zero, rsp_overflow, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(3'd2, 8'h7F, 8'h01, 0);
        run_cmd(3'd3, 8'h05, 8'h05, 0);
        run_cmd(3'd4, 8'h80, 8'h01, 0);
        run_cmd(3'd4, 8'h01, 8'h80, 0);
        run_cmd(3'd5, 8'h0F, 8'hF0, 0);
        run_cmd(3'd6, 8'h0D, 8'h0B, 0);
        run_cmd(3'd6, 8'h10, 8'h10, 1);
        run_cmd(3'd0, 8'hC3, 8'h5A, 5);
        run_cmd(3'd7, 8'h12, 8'h34, 0);

        // MUL_EN=0 instance: multiply must be rejected as illegal
        @(negedge clk);
        cmd_op     = 3'd6;
        cmd_a      = 8'h0D;
        cmd_b      = 8'h0B;
        cmd_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid0 = 1'b0;
        check("nomul_valid", 32'(rsp_valid0), 32'd1);
        check("nomul_err", 32'(rsp_err0), 32'd1);
        check("nomul_result", 32'(rsp_result0), 32'd0);
        check("nomul_zero_ovf", {30'd0, rsp_zero0, rsp_overflow0}, 32'd2);
        rsp_ready0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready0 = 1'b0;
        check("nomul_idle", 32'(cmd_ready0), 32'd1);

        // Leave nonzero response fields behind, then reset in the middle of a multiply
        run_cmd(3'd2, 8'h7F, 8'h01, 0);
        @(negedge clk);
        cmd_op    = 3'd6;
        cmd_a     = 8'hFF;
        cmd_b     = 8'hFF;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("mid_mul_busy", 32'(cmd_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_cmd_ready", 32'(cmd_ready), 32'd1);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_fields", {20'd0, rsp_result, 1'b0, rsp_zero, rsp_overflow, rsp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) quiet++;
        end
        check("no_rsp_after_reset", 32'(quiet), 32'd0);
        run_cmd(3'd2, 8'h02, 8'h03, 0);

        for (int n = 0; n < 40; n++) begin
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: MUL_EN, default 1, 1 enables the iterative multiply opcode and 0 treats it as illegal.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 MUL, 111 illegal.
REQ-007 cmd_a  input  8  operand A.
REQ-008 cmd_b  input  8  operand B.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_result  output  8  operation result.
REQ-012 rsp_zero  output  1  rsp_result == 0.
REQ-013 rsp_overflow  output  1  signed-overflow flag.
REQ-014 rsp_err  output  1  illegal opcode flag.

Function
REQ-015 SHALL instantiate exactly one ALU_8bit; all arithmetic and logic SHALL go through it. No second adder SHALL be used for results.
REQ-016 ALU controls per opcode (Ainvert/Binvert/op): AND 0/0/00, OR 0/0/01, ADD 0/0/10, SUB 0/1/10, SLT 0/1/11, NOR 1/1/00, MUL step 0/0/10.
REQ-017 FSM states: IDLE, EXEC, MUL, DONE; reset state IDLE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; handshake completes when cmd_valid & cmd_ready are both high on a rising edge.
REQ-019 On accept, the block SHALL register op, A, B.
- Legal non-MUL op: go to EXEC.
- MUL with MUL_EN=1: go to MUL.
- Op 111, or MUL with MUL_EN=0: go directly to DONE with result 0x00, zero 1, overflow 0, err 1.
REQ-020 EXEC lasts one cycle: ALU driven from the registered operands; result, zero and overflow captured; next state DONE.
- rsp_valid rises 2 cycles after the accept edge.
REQ-021 MUL: acc=0, mcand=A, mplier=B, 3-bit step counter=0. Each MUL cycle:
- if mplier[0], acc <= ALU(acc ADD mcand);
- mcand <<= 1; mplier >>= 1; counter++.
- After 8 steps, go to DONE with result = acc (low 8 bits of the product), zero = (acc==0), overflow 0, err 0.
- rsp_valid rises 9 cycles after the accept edge.
REQ-022 The ALU operand mux SHALL select registered A/B in EXEC and acc/mcand in MUL; ALU outputs are ignored in other states.
REQ-023 DONE: rsp_valid=1. rsp_result, rsp_zero, rsp_overflow, rsp_err SHALL remain stable until the response handshake; on rsp_ready go to IDLE.
REQ-024 A new command SHALL NOT be accepted in the cycle a response is handshaken; the minimum command-to-command spacing is 3 cycles (non-MUL, rsp_ready held high).
REQ-025 rsp_overflow SHALL equal the ALU overflow output for ADD and SUB, and 0 for all other ops.
REQ-026 SLT SHALL yield 0x01 when A<B signed, else 0x00. rsp_zero SHALL be derived from the captured result for every op.
REQ-027 cmd_* inputs SHALL be ignored outside IDLE; cmd_valid with no handshake has no effect.

Reset
REQ-028 rst_n low SHALL immediately, and at any state including mid-MUL, force: state IDLE, cmd_ready 1, rsp_valid 0, rsp_result 0x00, rsp_zero 0, rsp_overflow 0, rsp_err 0, and acc/mcand/mplier/counter 0.
REQ-029 An operation interrupted by reset SHALL produce no response; the first command after rst_n deasserts SHALL be processed normally.

Verification
REQ-030 ADD A=0x7F, B=0x01 -> rsp_result 0x80, overflow 1, zero 0, rsp_valid exactly 2 cycles after accept.
REQ-031 SUB A=0x05, B=0x05 -> 0x00, zero 1, overflow 0.
REQ-032 SLT cases:
- A=0x80, B=0x01 -> 0x01.
- A=0x01, B=0x80 -> 0x00.
- NOR A=0x0F, B=0xF0 -> 0x00, zero 1.
REQ-033 MUL cases:
- A=0x0D, B=0x0B -> 0x8F, rsp_valid 9 cycles after accept.
- A=0x10, B=0x10 -> 0x00, zero 1.
- MUL_EN=0 build: MUL -> err 1.
REQ-034 Backpressure: hold rsp_ready low 5 cycles in DONE -> response fields stable, cmd_ready 0, cmd_valid pulses ignored; then op 111 -> err 1, result 0x00.
REQ-035 Assert rst_n low at MUL step 4 -> outputs reach reset values without a clock edge; after release, ADD 0x02+0x03 -> 0x05.
